// File: rtl/timer_cnt_gen.sv
// Count-source and run-control front end for one 8051 Timer/Counter: prescaler,
// pin synchronisers, Tx edge detect, TRx/GATE qualification. Option macro: CNT_GEN_X2_EN (adds x2 port).
module timer_cnt_gen #(
  parameter int CLK_PER_MC  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CNT_GEN_X2_EN
  input  logic x2,
`endif
  input  logic tr,
  input  logic gate,
  input  logic c_t,
  input  logic t_pin,
  input  logic int_pin,
  output logic cnt_sig,
  output logic t_s,
  output logic mc_tick
);

  localparam int PW = (CLK_PER_MC > 1) ? $clog2(CLK_PER_MC) : 1;

  logic [PW-1:0]          r_pre_cnt;
  logic [PW-1:0]          w_term;
  logic [SYNC_STAGES-1:0] r_t_sync;
  logic [SYNC_STAGES-1:0] r_int_sync;
  logic                   r_t_samp;
  logic                   r_cnt_sig;
  logic                   w_t_sync;
  logic                   w_int_sync;
  logic                   w_edge;
  logic                   w_cnt_next;

`ifdef CNT_GEN_X2_EN
  assign w_term = x2 ? PW'(CLK_PER_MC / 2 - 1) : PW'(CLK_PER_MC - 1);
`else
  assign w_term = PW'(CLK_PER_MC - 1);
`endif

  // >= rather than == so a term that drops below pre_cnt (x2 change) wraps on the next clk
  assign mc_tick = (r_pre_cnt >= w_term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= mc_tick ? '0 : r_pre_cnt + PW'(1);
    end
  end

  // Synchronisers reset to 1 so idle-high pins never look like a falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t_sync   <= '1;
      r_int_sync <= '1;
    end else begin
      r_t_sync   <= {r_t_sync[SYNC_STAGES-2:0], t_pin};
      r_int_sync <= {r_int_sync[SYNC_STAGES-2:0], int_pin};
    end
  end

  assign w_t_sync   = r_t_sync[SYNC_STAGES-1];
  assign w_int_sync = r_int_sync[SYNC_STAGES-1];

  assign t_s = tr & (~gate | w_int_sync);

  // Sampled every machine cycle regardless of mode, so a c_t switch cannot see a stale edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t_samp <= 1'b1;
    end else if (mc_tick) begin
      r_t_samp <= w_t_sync;
    end
  end

  assign w_edge     = r_t_samp & ~w_t_sync;
  assign w_cnt_next = mc_tick & t_s & (c_t ? w_edge : 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_sig <= 1'b0;
    end else begin
      r_cnt_sig <= w_cnt_next;
    end
  end

  assign cnt_sig = r_cnt_sig;

endmodule

// File: tb/tb_timer_cnt_gen.sv
// Directed, table-driven bench for timer_cnt_gen (CLK_PER_MC=12, SYNC_STAGES=2).
module tb_timer_cnt_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tr = 1'b0, gate = 1'b0, c_t = 1'b0, t_pin = 1'b1, int_pin = 1'b1;
`ifdef CNT_GEN_X2_EN
  logic x2 = 1'b0;
`endif
  logic cnt_sig, t_s, mc_tick;

  timer_cnt_gen #(.CLK_PER_MC(12), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef CNT_GEN_X2_EN
    .x2(x2),
`endif
    .tr(tr),
    .gate(gate),
    .c_t(c_t),
    .t_pin(t_pin),
    .int_pin(int_pin),
    .cnt_sig(cnt_sig),
    .t_s(t_s),
    .mc_tick(mc_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int viol = 0;
  logic prev_cnt = 1'b0;

  typedef struct {
    logic tr;
    logic gate;
    logic c_t;
    logic int_pin;
    int   ncyc;
    int   exp_pulses;
    logic exp_ts;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clk: mc_tick is taken just before the edge, outputs 1 time unit after it
  task automatic step();
    logic tick_before;
    @(negedge clk);
    tick_before = mc_tick;
    @(posedge clk);
    #1;
    if (cnt_sig && (!tick_before || prev_cnt)) viol++;
    prev_cnt = cnt_sig;
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (cnt_sig) pulses++;
    end
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    while (!mc_tick && k < 30) begin
      step();
      k++;
    end
    check("wait_mc_tick", int'(mc_tick), 1);
  endtask

  task automatic do_reset();
    int first, second;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt_sig", int'(cnt_sig), 0);
    check("rst_mc_tick", int'(mc_tick), 0);
    check("rst_t_s", int'(t_s), int'(tr));
    rst_n = 1'b1;
    first = -1;
    second = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (mc_tick && first < 0) first = k;
      else if (mc_tick && second < 0 && k > first + 1) second = k;
    end
    check("first_tick", first, 11);
    check("second_tick", second, 23);
    $display("reset: first mc_tick at %0d, second at %0d", first, second);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p, last_fall;

    //          tr gate c_t int  ncyc pulses t_s
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 120, 10, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 120,  0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 120,  0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 120, 10, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1,  60,  0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 120, 10, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 120,  0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1,  24,  2, 1'b1};

    do_reset();

    for (int v = 0; v < 8; v++) begin
      tr = vecs[v].tr;
      gate = vecs[v].gate;
      c_t = vecs[v].c_t;
      int_pin = vecs[v].int_pin;
      repeat (3) step();
      count_pulses(vecs[v].ncyc, p);
      check($sformatf("vec%0d_pulses", v), p, vecs[v].exp_pulses);
      check($sformatf("vec%0d_t_s", v), int'(t_s), int'(vecs[v].exp_ts));
      $display("vec %0d: tr=%b gate=%b c_t=%b int=%b pulses=%0d t_s=%b",
               v, tr, gate, c_t, int_pin, p, t_s);
    end

    // GATE: int_pin reaches t_s after two synchroniser clks
    tr = 1'b1; gate = 1'b1; c_t = 1'b0; int_pin = 1'b1;
    repeat (4) step();
    int_pin = 1'b0;
    step(); check("gate_fall_1clk", int'(t_s), 1);
    step(); check("gate_fall_2clk", int'(t_s), 0);
    int_pin = 1'b1;
    step(); check("gate_rise_1clk", int'(t_s), 0);
    step(); check("gate_rise_2clk", int'(t_s), 1);
    $display("gate: int_pin sync latency sequence done");
    gate = 1'b0;

    // Counter mode, 24 high / 24 low
    c_t = 1'b1; t_pin = 1'b1;
    repeat (30) step();
    p = 0;
    last_fall = 0;
    for (int i = 0; i < 240; i++) begin
      t_pin = ((i / 24) % 2 == 0);
      if (i % 48 == 24) last_fall = i;
      step();
      if (cnt_sig) begin
        p++;
        check("edge_latency_ok", int'((i - last_fall + 1) <= 15), 1);
      end
    end
    check("counter_pulses", p, 5);
    $display("counter: %0d pulses for 5 falling edges", p);

    // Short low glitch between two samples
    t_pin = 1'b1;
    repeat (30) step();
    wait_tick();
    step();
    t_pin = 1'b0;
    repeat (3) step();
    t_pin = 1'b1;
    count_pulses(30, p);
    check("glitch_pulses", p, 0);
    $display("glitch: %0d pulses", p);

    // Switch to counter mode while Tx already low
    c_t = 1'b0; t_pin = 1'b0;
    repeat (30) step();
    c_t = 1'b1;
    count_pulses(36, p);
    check("ct_switch_pulses", p, 0);
    $display("c_t switch with t_pin low: %0d pulses", p);
    t_pin = 1'b1;
    c_t = 1'b0;
    repeat (30) step();

    // tr dropping before the tick edge suppresses; an issued pulse stays
    wait_tick();
    tr = 1'b0;
    step();
    check("tr_fall_suppress", int'(cnt_sig), 0);
    tr = 1'b1;
    wait_tick();
    step();
    check("pulse_issued", int'(cnt_sig), 1);
    tr = 1'b0;
    #1;
    check("pulse_not_retracted", int'(cnt_sig), 1);
    tr = 1'b1;
    $display("tr fall: suppression and no-retract checked");

    // Async reset in the middle of a pulse
    wait_tick();
    step();
    check("pre_reset_pulse", int'(cnt_sig), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt_sig", int'(cnt_sig), 0);
    check("async_rst_mc_tick", int'(mc_tick), 0);
    $display("reset mid-pulse: cnt_sig=%b", cnt_sig);
    do_reset();

`ifdef CNT_GEN_X2_EN
    x2 = 1'b1;
    repeat (3) step();
    count_pulses(120, p);
    check("x2_pulses", p, 20);
    $display("x2=1: %0d pulses in 120 clks", p);
    x2 = 1'b0;
    repeat (3) step();
    count_pulses(120, p);
    check("x2_off_pulses", p, 10);
    $display("x2=0: %0d pulses in 120 clks", p);
`endif

    check("pulse_shape_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
